// File: rtl/serial_alu_if.sv
// serial_alu_if: controller-to-ALU start/done bus; carries cout when SERIAL_ALU_CARRY_OUT_EN is defined
interface serial_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       control;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic             zero;
   logic             negative;
   logic             overflow;
`ifdef SERIAL_ALU_CARRY_OUT_EN
   logic             cout;
`endif
   modport master (
      output start, a, b, control,
      input  out, busy, done, zero, negative, overflow
`ifdef SERIAL_ALU_CARRY_OUT_EN
      , input cout
`endif
   );
   modport slave (
      input  start, a, b, control,
      output out, busy, done, zero, negative, overflow
`ifdef SERIAL_ALU_CARRY_OUT_EN
      , output cout
`endif
   );
endinterface

// File: rtl/serial_alu.sv
// serial_alu: bit-serial add/sub/logic ALU, one bit per clock LSB first, WIDTH+1 cycle issue interval.
// Define SERIAL_ALU_CARRY_OUT_EN to add the cout port (final MSB carry of add/sub).
module serial_alu #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         reset,
   serial_alu_if.slave bus
);
   localparam int IW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_r, b_r, res, res_n, out_r;
   logic [2:0]       ctl;
   logic             carry, carry_n, ai, bi, bx, sum, rbit, arith, last;
   logic             zero_r, neg_r, ovf_r;
   always_comb begin
      ai      = a_r[idx];
      bi      = b_r[idx];
      arith   = ctl[2:1] == 2'b01;
      bx      = bi ^ (ctl == 3'd3);
      sum     = ai ^ bx ^ carry;
      carry_n = (ai & bx) | (ai & carry) | (bx & carry);
      rbit    = arith ? sum :
                ctl == 3'd4 ? ai & bi :
                ctl == 3'd5 ? ai | bi :
                ctl == 3'd6 ? ~(ai | bi) :
                ctl == 3'd7 ? ai ^ bi : 1'b0;
      res_n   = {rbit, res[WIDTH-1:1]};
      last    = idx == IW'(WIDTH - 1);
   end
`ifdef SERIAL_ALU_CARRY_OUT_EN
   logic cout_r;
   always_ff @(posedge clk)
      if (reset) cout_r <= 1'b0;
      else if (state == RUN && last) cout_r <= arith & carry_n;
   assign bus.cout = cout_r;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         ctl    <= '0;
         carry  <= 1'b0;
         res    <= '0;
         out_r  <= '0;
         zero_r <= 1'b0;
         neg_r  <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (state == RUN) begin
         res   <= res_n;
         carry <= carry_n;
         idx   <= idx + IW'(1);
         if (last) begin
            out_r  <= res_n;
            zero_r <= res_n == '0;
            neg_r  <= res_n[WIDTH-1];
            // overflow = carry into MSB xor carry out of MSB
            ovf_r  <= arith & (carry ^ carry_n);
            state  <= DONE;
         end
      end else begin
         state <= bus.start ? RUN : IDLE;
         if (bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            ctl   <= bus.control;
            carry <= bus.control == 3'd3;
            idx   <= '0;
            res   <= '0;
         end
      end
   end
   assign bus.out      = out_r;
   assign bus.busy     = state == RUN;
   assign bus.done     = state == DONE;
   assign bus.zero     = zero_r;
   assign bus.negative = neg_r;
   assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed vectors with a result scoreboard; monitor pops on every done pulse.
module tb_serial_alu;
   localparam int W = 32;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   typedef struct {
      logic [W-1:0] out;
      logic z, n, v, c;
      int at;
      int id;
   } exp_t;
   exp_t q[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   serial_alu_if #(.WIDTH(W)) bus();
   serial_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done cyc=%0d got=1 want=0", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("op%0d_out", e.id), bus.out, e.out);
            chk($sformatf("op%0d_zero", e.id), W'(bus.zero), W'(e.z));
            chk($sformatf("op%0d_neg", e.id), W'(bus.negative), W'(e.n));
            chk($sformatf("op%0d_ovf", e.id), W'(bus.overflow), W'(e.v));
            chk($sformatf("op%0d_done_cycle", e.id), W'(cyc), W'(e.at));
`ifdef SERIAL_ALU_CARRY_OUT_EN
            chk($sformatf("op%0d_cout", e.id), W'(bus.cout), W'(e.c));
`endif
         end
      end
   end

   task automatic issue(int id, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] c,
                        logic [W-1:0] o, logic z, logic n, logic v, logic co, bit hold);
      int k = 0;
      bus.a = a;
      bus.b = b;
      bus.control = c;
      bus.start = 1'b1;
      while (bus.busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         total++;
         bad++;
         $display("FAIL issue%0d_timeout got=busy want=idle", id);
      end
      @(posedge clk);
      #1;
      q.push_back('{out: o, z: z, n: n, v: v, c: co, at: cyc + W, id: id});
      if (!hold) bus.start = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() > 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) begin
         total++;
         bad++;
         $display("FAIL drain_timeout got=%0d want=0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int low;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.control = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out", bus.out, '0);
      chk("rst_busy", W'(bus.busy), '0);
      chk("rst_done", W'(bus.done), '0);
      chk("rst_flags", W'({bus.zero, bus.negative, bus.overflow}), '0);
      reset = 1'b0;
      // arithmetic
      issue(1, 32'h7FFFFFFF, 32'h00000001, 3'd2, 32'h80000000, 0, 1, 1, 0, 0);
      drain();
      issue(2, 32'd5, 32'd5, 3'd3, 32'h0, 1, 0, 0, 1, 0);
      drain();
      issue(3, 32'd0, 32'd1, 3'd3, 32'hFFFFFFFF, 0, 1, 0, 0, 0);
      drain();
      // back-to-back logic ops with start held high
      issue(4, 32'hF0F0F0F0, 32'hFFFF0000, 3'd7, 32'h0F0FF0F0, 0, 0, 0, 0, 1);
      issue(5, 32'h0, 32'h0, 3'd6, 32'hFFFFFFFF, 0, 1, 0, 0, 1);
      issue(6, 32'hFFFF0000, 32'h0000FFFF, 3'd4, 32'h0, 1, 0, 0, 0, 0);
      drain();
      issue(7, 32'h12340000, 32'h00005678, 3'd5, 32'h12345678, 0, 0, 0, 0, 0);
      drain();
      // start while busy is ignored
      issue(8, 32'd3, 32'd4, 3'd2, 32'd7, 0, 0, 0, 0, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.a = 32'h100;
      bus.b = 32'h100;
      bus.control = 3'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      low = 0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         if (bus.done) break;
         if (!bus.busy) low++;
      end
      chk("busy_held", W'(low), '0);
      drain();
      issue(9, 32'h80000000, 32'd1, 3'd3, 32'h7FFFFFFF, 0, 0, 1, 1, 0);
      drain();
      // reset during RUN cycle 16
      issue(10, 32'd1, 32'd2, 3'd2, 32'd3, 0, 0, 0, 0, 0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      @(negedge clk);
      chk("midrst_out", bus.out, '0);
      chk("midrst_busy", W'(bus.busy), '0);
      chk("midrst_done", W'(bus.done), '0);
      chk("midrst_flags", W'({bus.zero, bus.negative, bus.overflow}), '0);
`ifdef SERIAL_ALU_CARRY_OUT_EN
      chk("midrst_cout", W'(bus.cout), '0);
`endif
      reset = 1'b0;
      repeat (W + 4) @(negedge clk);
      issue(11, 32'd10, 32'd20, 3'd2, 32'd30, 0, 0, 0, 0, 0);
      drain();
      // reserved codes
      issue(12, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 32'h0, 1, 0, 0, 0, 0);
      drain();
      issue(13, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h0, 1, 0, 0, 0, 0);
      drain();
      chk("held_zero", W'(bus.zero), W'(1));
      chk("held_out", bus.out, '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
